// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// =============================================================================
//  Module   : hazard_ctrl_pkg
//  Purpose  : Shared pipeline types and constants for the hazard controller.
//  Revision : 1.0  initial release
// =============================================================================
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    localparam logic [1:0] RESULT_LOAD = 2'b01;

    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic stall_e;
        logic stall_m;
        logic flush_d;
        logic flush_e;
        logic flush_w;
    } hz_ctl_t;

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// =============================================================================
//  Module   : hazard_ctrl_if
//  Purpose  : Pipeline-to-hazard-unit signal bundle (pipeline = master).
//  Revision : 1.0  initial release
// =============================================================================
interface hazard_ctrl_if
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic [REG_AW-1:0] Rs1D;
    logic [REG_AW-1:0] Rs2D;
    logic [REG_AW-1:0] RdD;
    logic              LongOpD;
    logic [REG_AW-1:0] Rs1E;
    logic [REG_AW-1:0] Rs2E;
    logic [REG_AW-1:0] RdE;
    logic [1:0]        ResultSrcE;
    logic [1:0]        PCSrcE;
    logic              LongIssueE;
    logic [REG_AW-1:0] RdM;
    logic              RegWriteM;
    logic [REG_AW-1:0] RdW;
    logic              RegWriteW;
    logic              MemReadyM;
    logic              LongDone;
    logic [REG_AW-1:0] LongRd;

    fwd_sel_e          ForwardAE;
    fwd_sel_e          ForwardBE;
    logic              StallFetch;
    logic              StallDecode;
    logic              StallExecute;
    logic              StallMemory;
    logic              FlushDecode;
    logic              FlushExecute;
    logic              FlushWriteback;
    logic              LongBusy;
    logic [CNT_W-1:0]  StallCount;

    modport master (
        output Rs1D, Rs2D, RdD, LongOpD, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
               LongIssueE, RdM, RegWriteM, RdW, RegWriteW, MemReadyM,
               LongDone, LongRd,
        input  ForwardAE, ForwardBE, StallFetch, StallDecode, StallExecute,
               StallMemory, FlushDecode, FlushExecute, FlushWriteback,
               LongBusy, StallCount
    );

    modport slave (
        input  Rs1D, Rs2D, RdD, LongOpD, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
               LongIssueE, RdM, RegWriteM, RdW, RegWriteW, MemReadyM,
               LongDone, LongRd,
        output ForwardAE, ForwardBE, StallFetch, StallDecode, StallExecute,
               StallMemory, FlushDecode, FlushExecute, FlushWriteback,
               LongBusy, StallCount
    );

endinterface
`default_nettype wire

// File: rtl/hazard_ctrl_scoreboard.sv
`default_nettype none
// =============================================================================
//  Module   : hazard_scoreboard
//  Purpose  : Per-register pending bits for in-flight long-latency results.
//  Revision : 1.0  initial release
// =============================================================================
module hazard_scoreboard
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int NUM_REGS = 2**REG_AW
) (
    input  wire logic                clk,
    input  wire logic                rst_n,
    input  wire logic                set_en,
    input  wire logic [REG_AW-1:0]   set_idx,
    input  wire logic                clr_en,
    input  wire logic [REG_AW-1:0]   clr_idx,
    output logic      [NUM_REGS-1:0] pending
);

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_entry
        if (gi == 0) begin : g_zero
            // x0 is hardwired, so it can never be pending
            assign pending[gi] = 1'b0;
        end else begin : g_bit
            localparam logic [REG_AW-1:0] c_idx = REG_AW'(gi);
            logic r_bit;

            // Set is tested first so a same-cycle reissue keeps the bit
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_bit <= 1'b0;
                end else if (set_en && (set_idx == c_idx)) begin
                    r_bit <= 1'b1;
                end else if (clr_en && (clr_idx == c_idx)) begin
                    r_bit <= 1'b0;
                end
            end

            assign pending[gi] = r_bit;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// =============================================================================
//  Module   : hazard_ctrl
//  Purpose  : Pipeline forwarding, stall/flush priority and long-op tracking.
//  Revision : 1.0  initial release
// =============================================================================
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int NUM_REGS = 2**REG_AW,
    parameter int CNT_W    = 32
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    hazard_ctrl_if.slave hz
);

    logic [NUM_REGS-1:0] w_pending;
    logic                r_long_busy;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic                w_load_use;
    logic                w_sb_hz;
    logic                w_struct_hz;
    logic                w_dec_hz;
    logic                w_redirect;
    logic                w_issue;
    hz_ctl_t             w_ctl;

    function automatic fwd_sel_e f_fwd(
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] rdm,
        input logic              wem,
        input logic [REG_AW-1:0] rdw,
        input logic              wew
    );
        if ((rs != '0) && wem && (rs == rdm)) begin
            return FWD_M;
        end else if ((rs != '0) && wew && (rs == rdw)) begin
            return FWD_W;
        end
        return FWD_RF;
    endfunction

    // A register is busy if already pending or being claimed by the issuing op
    function automatic logic f_busy_reg(
        input logic [REG_AW-1:0]   idx,
        input logic [NUM_REGS-1:0] pend,
        input logic                iss,
        input logic [REG_AW-1:0]   rde
    );
        logic hit;
        hit = 1'b0;
        if (idx != '0) begin
            if (int'(idx) < NUM_REGS) begin
                hit = pend[idx];
            end
            if (iss && (idx == rde)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    assign hz.ForwardAE = f_fwd(hz.Rs1E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
    assign hz.ForwardBE = f_fwd(hz.Rs2E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);

    assign w_load_use  = (hz.ResultSrcE == RESULT_LOAD) && (hz.RdE != '0) &&
                         ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
    assign w_sb_hz     = f_busy_reg(hz.Rs1D, w_pending, hz.LongIssueE, hz.RdE) ||
                         f_busy_reg(hz.Rs2D, w_pending, hz.LongIssueE, hz.RdE) ||
                         f_busy_reg(hz.RdD,  w_pending, hz.LongIssueE, hz.RdE);
    assign w_struct_hz = hz.LongOpD && (r_long_busy || hz.LongIssueE);
    assign w_dec_hz    = w_load_use || w_sb_hz || w_struct_hz;
    assign w_redirect  = (hz.PCSrcE != 2'b00);

    // Memory stall freezes everything; the deferred response fires once it lifts
    always_comb begin
        w_ctl = '0;
        if (!hz.MemReadyM) begin
            w_ctl.stall_f = 1'b1;
            w_ctl.stall_d = 1'b1;
            w_ctl.stall_e = 1'b1;
            w_ctl.stall_m = 1'b1;
            w_ctl.flush_w = 1'b1;
        end else if (w_redirect) begin
            w_ctl.flush_d = 1'b1;
            w_ctl.flush_e = 1'b1;
        end else if (w_dec_hz) begin
            w_ctl.stall_f = 1'b1;
            w_ctl.stall_d = 1'b1;
            w_ctl.flush_e = 1'b1;
        end
    end

    assign hz.StallFetch     = w_ctl.stall_f;
    assign hz.StallDecode    = w_ctl.stall_d;
    assign hz.StallExecute   = w_ctl.stall_e;
    assign hz.StallMemory    = w_ctl.stall_m;
    assign hz.FlushDecode    = w_ctl.flush_d;
    assign hz.FlushExecute   = w_ctl.flush_e;
    assign hz.FlushWriteback = w_ctl.flush_w;

    assign w_issue = hz.LongIssueE && !w_ctl.stall_e && (hz.RdE != '0);

    hazard_scoreboard #(
        .REG_AW   (REG_AW),
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .clk     (clk),
        .rst_n   (rst_n),
        .set_en  (w_issue),
        .set_idx (hz.RdE),
        .clr_en  (hz.LongDone),
        .clr_idx (hz.LongRd),
        .pending (w_pending)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_long_busy <= 1'b0;
        end else if (w_issue) begin
            r_long_busy <= 1'b1;
        end else if (hz.LongDone) begin
            r_long_busy <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_ctl.stall_d && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign hz.LongBusy   = r_long_busy;
    assign hz.StallCount = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// =============================================================================
//  Module   : tb_hazard_ctrl
//  Purpose  : Directed vector table plus multi-cycle sequences for hazard_ctrl.
//  Revision : 1.0  initial release
// =============================================================================
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    typedef struct {
        logic [4:0] rs1d, rs2d, rdd;
        logic       longopd;
        logic [4:0] rs1e, rs2e, rde;
        logic [1:0] rsrc, pcsrc;
        logic [4:0] rdm;
        logic       rwm;
        logic [4:0] rdw;
        logic       rww;
        logic       memrdy;
        logic [1:0] fa, fb;
        logic [6:0] ctl;   // {sf, sd, se, sm, fd, fe, fw}
    } vec_t;

    localparam int NVEC = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   exp_cnt = 0;
    int   exp_cnt4 = 0;
    vec_t vecs [NVEC];

    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_AW(5), .CNT_W(32)) hz ();
    hazard_ctrl_if #(.REG_AW(5), .CNT_W(4))  hz4 ();

    hazard_ctrl #(.REG_AW(5), .NUM_REGS(32), .CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    hazard_ctrl #(.REG_AW(5), .NUM_REGS(32), .CNT_W(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz4)
    );

    assign hz4.Rs1D       = hz.Rs1D;
    assign hz4.Rs2D       = hz.Rs2D;
    assign hz4.RdD        = hz.RdD;
    assign hz4.LongOpD    = hz.LongOpD;
    assign hz4.Rs1E       = hz.Rs1E;
    assign hz4.Rs2E       = hz.Rs2E;
    assign hz4.RdE        = hz.RdE;
    assign hz4.ResultSrcE = hz.ResultSrcE;
    assign hz4.PCSrcE     = hz.PCSrcE;
    assign hz4.LongIssueE = hz.LongIssueE;
    assign hz4.RdM        = hz.RdM;
    assign hz4.RegWriteM  = hz.RegWriteM;
    assign hz4.RdW        = hz.RdW;
    assign hz4.RegWriteW  = hz.RegWriteW;
    assign hz4.MemReadyM  = hz.MemReadyM;
    assign hz4.LongDone   = hz.LongDone;
    assign hz4.LongRd     = hz.LongRd;

    function automatic vec_t mk(
        input int rs1d, input int rs2d, input int rdd, input int longopd,
        input int rs1e, input int rs2e, input int rde,
        input int rsrc, input int pcsrc,
        input int rdm, input int rwm, input int rdw, input int rww,
        input int memrdy, input int fa, input int fb, input int ctl
    );
        vec_t v;
        v.rs1d = 5'(rs1d);  v.rs2d = 5'(rs2d);  v.rdd = 5'(rdd);
        v.longopd = 1'(longopd);
        v.rs1e = 5'(rs1e);  v.rs2e = 5'(rs2e);  v.rde = 5'(rde);
        v.rsrc = 2'(rsrc);  v.pcsrc = 2'(pcsrc);
        v.rdm = 5'(rdm);    v.rwm = 1'(rwm);
        v.rdw = 5'(rdw);    v.rww = 1'(rww);
        v.memrdy = 1'(memrdy);
        v.fa = 2'(fa);      v.fb = 2'(fb);
        v.ctl = 7'(ctl);
        return v;
    endfunction

    function automatic logic [6:0] ctl_now();
        return {hz.StallFetch, hz.StallDecode, hz.StallExecute, hz.StallMemory,
                hz.FlushDecode, hz.FlushExecute, hz.FlushWriteback};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        hz.Rs1D = '0;  hz.Rs2D = '0;  hz.RdD = '0;  hz.LongOpD = 1'b0;
        hz.Rs1E = '0;  hz.Rs2E = '0;  hz.RdE = '0;
        hz.ResultSrcE = 2'b00;  hz.PCSrcE = 2'b00;  hz.LongIssueE = 1'b0;
        hz.RdM = '0;  hz.RegWriteM = 1'b0;  hz.RdW = '0;  hz.RegWriteW = 1'b0;
        hz.MemReadyM = 1'b1;  hz.LongDone = 1'b0;  hz.LongRd = '0;
    endtask

    // Check one cycle's outputs, clock it, and advance the stall-count model
    task automatic cyc(input string nm, input logic [6:0] ectl,
                       input logic [1:0] efa, input logic [1:0] efb,
                       input logic ebusy);
        #2;
        chk({nm, " ctl"},   32'(ctl_now()),          32'(ectl));
        chk({nm, " fwdA"},  32'(hz.ForwardAE),       32'(efa));
        chk({nm, " fwdB"},  32'(hz.ForwardBE),       32'(efb));
        chk({nm, " busy"},  32'(hz.LongBusy),        32'(ebusy));
        chk({nm, " cnt"},   hz.StallCount,           32'(exp_cnt));
        chk({nm, " cnt4"},  32'(hz4.StallCount),     32'(exp_cnt4));
        @(posedge clk);
        #1;
        if (!rst_n) begin
            exp_cnt  = 0;
            exp_cnt4 = 0;
        end else if (ectl[5]) begin
            exp_cnt++;
            if (exp_cnt4 != 15) exp_cnt4++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //         rs1d rs2d rdd lop rs1e rs2e rde rsrc pcs rdm rwm rdw rww mrdy fa  fb  ctl
        vecs[0]  = mk(0, 0, 0, 0,  0, 0, 0,  0, 0,  0, 0, 0, 0,  1,  0, 0, 'b0000000);
        vecs[1]  = mk(0, 0, 0, 0,  5, 0, 0,  0, 0,  5, 1, 5, 1,  1,  2, 0, 'b0000000);
        vecs[2]  = mk(0, 0, 0, 0,  0, 0, 0,  0, 0,  0, 1, 0, 1,  1,  0, 0, 'b0000000);
        vecs[3]  = mk(0, 0, 0, 0,  0, 6, 0,  0, 0,  6, 0, 6, 1,  1,  0, 1, 'b0000000);
        vecs[4]  = mk(0, 0, 0, 0,  3, 4, 0,  0, 0,  3, 1, 4, 1,  1,  2, 1, 'b0000000);
        vecs[5]  = mk(0, 0, 0, 0,  3, 3, 0,  0, 0,  3, 0, 3, 0,  1,  0, 0, 'b0000000);
        vecs[6]  = mk(0, 7, 0, 0,  0, 0, 7,  1, 0,  0, 0, 0, 0,  1,  0, 0, 'b1100010);
        vecs[7]  = mk(8, 9, 0, 0,  0, 0, 7,  1, 0,  0, 0, 0, 0,  1,  0, 0, 'b0000000);
        vecs[8]  = mk(7, 0, 0, 0,  0, 0, 7,  2, 0,  0, 0, 0, 0,  1,  0, 0, 'b0000000);
        vecs[9]  = mk(0, 0, 0, 0,  0, 0, 0,  0, 1,  0, 0, 0, 0,  1,  0, 0, 'b0000110);
        vecs[10] = mk(7, 0, 0, 0,  0, 0, 7,  1, 2,  0, 0, 0, 0,  1,  0, 0, 'b0000110);
        vecs[11] = mk(7, 0, 0, 0,  0, 0, 7,  1, 0,  0, 0, 0, 0,  0,  0, 0, 'b1111001);
        vecs[12] = mk(0, 0, 0, 0,  0, 0, 0,  0, 1,  0, 0, 0, 0,  0,  0, 0, 'b1111001);
        vecs[13] = mk(0, 0, 0, 1,  0, 0, 0,  0, 0,  0, 0, 0, 0,  1,  0, 0, 'b0000000);
        vecs[14] = mk(0, 0, 7, 0,  0, 0, 7,  1, 0,  0, 0, 0, 0,  1,  0, 0, 'b0000000);
        vecs[15] = mk(0, 0, 0, 0,  2, 2, 0,  0, 0,  2, 1, 2, 1,  1,  2, 2, 'b0000000);

        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            idle();
            hz.Rs1D = vecs[i].rs1d;  hz.Rs2D = vecs[i].rs2d;  hz.RdD = vecs[i].rdd;
            hz.LongOpD = vecs[i].longopd;
            hz.Rs1E = vecs[i].rs1e;  hz.Rs2E = vecs[i].rs2e;  hz.RdE = vecs[i].rde;
            hz.ResultSrcE = vecs[i].rsrc;  hz.PCSrcE = vecs[i].pcsrc;
            hz.RdM = vecs[i].rdm;  hz.RegWriteM = vecs[i].rwm;
            hz.RdW = vecs[i].rdw;  hz.RegWriteW = vecs[i].rww;
            hz.MemReadyM = vecs[i].memrdy;
            cyc($sformatf("vec%0d", i), vecs[i].ctl, vecs[i].fa, vecs[i].fb, 1'b0);
        end

        // Memory stall with a pending redirect, then the redirect fires
        for (int k = 0; k < 3; k++) begin
            idle(); hz.PCSrcE = 2'b01; hz.MemReadyM = 1'b0;
            cyc("memstall", 7'b1111001, 2'b00, 2'b00, 1'b0);
        end
        idle(); hz.PCSrcE = 2'b01;
        cyc("memrelease", 7'b0000110, 2'b00, 2'b00, 1'b0);

        // Long op to x9 with a dependent reader: six stall cycles
        idle(); hz.LongIssueE = 1'b1; hz.RdE = 5'd9; hz.Rs1D = 5'd9;
        cyc("issue raw", 7'b1100010, 2'b00, 2'b00, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            idle(); hz.Rs1D = 5'd9;
            if (k == 5) begin hz.LongDone = 1'b1; hz.LongRd = 5'd9; end
            cyc("long wait", 7'b1100010, 2'b00, 2'b00, 1'b1);
        end
        idle(); hz.Rs1D = 5'd9;
        cyc("long released", 7'b0000000, 2'b00, 2'b00, 1'b0);

        // Structural and WAW hazards while a long op is in flight
        idle(); hz.LongIssueE = 1'b1; hz.RdE = 5'd9; hz.LongOpD = 1'b1;
        cyc("struct issue", 7'b1100010, 2'b00, 2'b00, 1'b0);
        idle(); hz.LongOpD = 1'b1;
        cyc("struct busy", 7'b1100010, 2'b00, 2'b00, 1'b1);
        idle();
        cyc("busy no dep", 7'b0000000, 2'b00, 2'b00, 1'b1);
        idle(); hz.RdD = 5'd9;
        cyc("waw", 7'b1100010, 2'b00, 2'b00, 1'b1);
        idle(); hz.Rs1D = 5'd4; hz.Rs2D = 5'd9;
        cyc("raw rs2", 7'b1100010, 2'b00, 2'b00, 1'b1);
        idle(); hz.Rs1D = 5'd10;
        cyc("other reg", 7'b0000000, 2'b00, 2'b00, 1'b1);

        // Done and reissue to the same register in one cycle: set wins
        idle(); hz.LongDone = 1'b1; hz.LongRd = 5'd9; hz.LongIssueE = 1'b1; hz.RdE = 5'd9;
        cyc("done+issue", 7'b0000000, 2'b00, 2'b00, 1'b1);
        idle(); hz.Rs1D = 5'd9;
        cyc("set wins", 7'b1100010, 2'b00, 2'b00, 1'b1);
        idle(); hz.LongDone = 1'b1; hz.LongRd = 5'd9;
        cyc("done", 7'b0000000, 2'b00, 2'b00, 1'b1);
        idle(); hz.Rs1D = 5'd9;
        cyc("cleared", 7'b0000000, 2'b00, 2'b00, 1'b0);

        // Issue is held off by a memory stall; done is honoured during one
        idle(); hz.LongIssueE = 1'b1; hz.RdE = 5'd12; hz.MemReadyM = 1'b0;
        cyc("issue memstall", 7'b1111001, 2'b00, 2'b00, 1'b0);
        idle(); hz.Rs1D = 5'd12;
        cyc("no pending", 7'b0000000, 2'b00, 2'b00, 1'b0);
        idle(); hz.LongIssueE = 1'b1; hz.RdE = 5'd13;
        cyc("issue13", 7'b0000000, 2'b00, 2'b00, 1'b0);
        idle(); hz.LongDone = 1'b1; hz.LongRd = 5'd13; hz.MemReadyM = 1'b0;
        cyc("done in memstall", 7'b1111001, 2'b00, 2'b00, 1'b1);
        idle(); hz.Rs1D = 5'd13;
        cyc("after done", 7'b0000000, 2'b00, 2'b00, 1'b0);

        // Reset while a long op is in flight
        idle(); hz.LongIssueE = 1'b1; hz.RdE = 5'd9;
        cyc("issue9", 7'b0000000, 2'b00, 2'b00, 1'b0);
        idle(); hz.Rs1D = 5'd9; rst_n = 1'b0;
        cyc("in reset", 7'b1100010, 2'b00, 2'b00, 1'b1);
        rst_n = 1'b1;
        idle(); hz.Rs1D = 5'd9;
        cyc("post reset", 7'b0000000, 2'b00, 2'b00, 1'b0);

        // Drive the narrow counter into saturation
        for (int k = 0; k < 17; k++) begin
            idle(); hz.ResultSrcE = 2'b01; hz.RdE = 5'd7; hz.Rs1D = 5'd7;
            cyc("sat", 7'b1100010, 2'b00, 2'b00, 1'b0);
        end
        idle();
        cyc("final", 7'b0000000, 2'b00, 2'b00, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
